// File: rtl/image_loader.sv
`timescale 1ns/1ps
// image_loader: receives 8-bit grayscale pixels over a valid/ready byte stream,
// converts each one to signed Q2.13 and writes it into the classifier's
// input-layer BRAM. After the last pixel of an image it pulses start_conversion
// once, then refuses pixels until the classifier reports end_of_conversion.
//
// Optional build macro: IMAGE_LOADER_BINARIZE_EN
//   defined   -> pixels >= THRESHOLD become 1.0 (16'h2000), others 0.0
//   undefined -> linear scaling, data = rx_data / 256 in Q2.13
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous, active-high reset
//   rx_data[7:0]        pixel value, unsigned
//   rx_valid            rx_data valid
//   rx_ready            loader accepts a pixel (transfer = rx_valid && rx_ready)
//   bram_write_enable   BRAM write strobe
//   bram_write_address  BRAM write address
//   bram_write_data     Q2.13 pixel value
//   start_conversion    one-cycle pulse to the classifier
//   end_of_conversion   classifier done (pulse or level)
//   busy                high whenever the loader is not in IDLE
module image_loader #(
    parameter int unsigned NUM_PIXELS = 784,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned BASE_ADDR  = 0
`ifdef IMAGE_LOADER_BINARIZE_EN
    ,
    parameter int unsigned THRESHOLD  = 128
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              bram_write_enable,
    output logic [ADDR_W-1:0] bram_write_address,
    output logic [15:0]       bram_write_data,
    output logic              start_conversion,
    input  logic              end_of_conversion,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                rx_ready_q, rx_ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         data_q, data_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic [15:0]         pix_conv;

    // Pixel to Q2.13 conversion
    always_comb begin
`ifdef IMAGE_LOADER_BINARIZE_EN
        pix_conv = (32'(rx_data) >= THRESHOLD) ? 16'h2000 : 16'h0000;
`else
        pix_conv = {3'b000, rx_data, 5'b00000};
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_ready_d = rx_ready_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        start_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d    = S_LOAD;
                rx_ready_d = 1'b1;
            end
            S_LOAD: begin
                rx_ready_d = 1'b1;
                if (rx_valid && rx_ready_q) begin
                    we_d   = 1'b1;
                    addr_d = BASE_A + cnt_q;
                    data_d = pix_conv;
                    // Last pixel: stop accepting in the same cycle the final write appears
                    if (cnt_q == LAST_IDX) begin
                        cnt_d      = '0;
                        rx_ready_d = 1'b0;
                        state_d    = S_START;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            S_START: begin
                start_d    = 1'b1;
                cnt_d      = '0;
                addr_d     = BASE_A;
                rx_ready_d = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                rx_ready_d = 1'b0;
                // Only this state samples end_of_conversion, so a held level cannot retrigger
                if (end_of_conversion) begin
                    state_d    = S_LOAD;
                    rx_ready_d = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                rx_ready_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= BASE_A;
            data_q     <= 16'h0000;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_ready           = rx_ready_q;
    assign bram_write_enable  = we_q;
    assign bram_write_address = addr_q;
    assign bram_write_data    = data_q;
    assign start_conversion   = start_q;
    assign busy               = busy_q;

endmodule
